// File: rtl/varredor_primos_pkg.sv
// Shared types and constants for the prime range scanner and its detector.
package varredor_primos_pkg;

  localparam int WIDTH_DEFAULT     = 16;
  localparam int CNT_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Every composite below 2^16 has a prime factor no larger than 251.
  localparam int NUM_SMALL_PRIMES = 54;
  localparam logic [7:0] SMALL_PRIMES [NUM_SMALL_PRIMES] = '{
    8'd2,   8'd3,   8'd5,   8'd7,   8'd11,  8'd13,  8'd17,  8'd19,  8'd23,
    8'd29,  8'd31,  8'd37,  8'd41,  8'd43,  8'd47,  8'd53,  8'd59,  8'd61,
    8'd67,  8'd71,  8'd73,  8'd79,  8'd83,  8'd89,  8'd97,  8'd101, 8'd103,
    8'd107, 8'd109, 8'd113, 8'd127, 8'd131, 8'd137, 8'd139, 8'd149, 8'd151,
    8'd157, 8'd163, 8'd167, 8'd173, 8'd179, 8'd181, 8'd191, 8'd193, 8'd197,
    8'd199, 8'd211, 8'd223, 8'd227, 8'd229, 8'd233, 8'd239, 8'd241, 8'd251
  };

endpackage

// File: rtl/varredor_primos_primo.sv
// Combinational prime detector: f=1 when n is prime (0 and 1 are not).
module primo
  import varredor_primos_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] n,
  output logic             f
);

  logic [NUM_SMALL_PRIMES-1:0] has_factor;

  // A small prime only disqualifies n when it divides n and is not n itself.
  for (genvar gi = 0; gi < NUM_SMALL_PRIMES; gi++) begin : g_div
    localparam logic [WIDTH-1:0] P = WIDTH'(SMALL_PRIMES[gi]);
    assign has_factor[gi] = ((n % P) == '0) && (n != P);
  end

  assign f = (n >= WIDTH'(2)) && (has_factor == '0);

endmodule

// File: rtl/varredor_primos.sv
// Sweeps N over [lo, hi], one candidate per clock, and streams each prime out
// on a valid/ready handshake while counting them.
module varredor_primos
  import varredor_primos_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     lo,
  input  logic [WIDTH-1:0]     hi,
  input  logic                 out_ready,
  output logic                 prime_valid,
  output logic [WIDTH-1:0]     prime_value,
  output logic [CNT_WIDTH-1:0] prime_count,
  output logic                 busy,
  output logic                 done,
  output logic                 range_error
);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     n_q, n_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     prime_value_q, prime_value_d;
  logic                 prime_valid_q, prime_valid_d;
  logic [CNT_WIDTH-1:0] prime_count_q, prime_count_d;
  logic                 range_error_q, range_error_d;
  logic                 is_prime;

  primo #(.WIDTH(WIDTH)) u_primo (
    .n (n_q),
    .f (is_prime)
  );

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    hi_d          = hi_q;
    prime_value_d = prime_value_q;
    prime_valid_d = prime_valid_q;
    prime_count_d = prime_count_q;
    range_error_d = range_error_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // The lower bound is consumed immediately as the first candidate.
          hi_d          = hi;
          prime_count_d = '0;
          range_error_d = 1'b0;
          if (lo > hi) begin
            range_error_d = 1'b1;
            state_d       = DONE;
          end else begin
            n_d     = lo;
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (is_prime) begin
          prime_value_d = n_q;
          prime_valid_d = 1'b1;
          prime_count_d = prime_count_q + CNT_WIDTH'(1);
          state_d       = EMIT;
        end else if (n_q == hi_q) begin
          state_d = DONE;
        end else begin
          n_d = n_q + WIDTH'(1);
        end
      end
      EMIT: begin
        // End test precedes the increment so hi=all-ones never wraps N.
        if (out_ready) begin
          prime_valid_d = 1'b0;
          if (n_q == hi_q) begin
            state_d = DONE;
          end else begin
            n_d     = n_q + WIDTH'(1);
            state_d = SCAN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      n_q           <= '0;
      hi_q          <= '0;
      prime_value_q <= '0;
      prime_valid_q <= 1'b0;
      prime_count_q <= '0;
      range_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      hi_q          <= hi_d;
      prime_value_q <= prime_value_d;
      prime_valid_q <= prime_valid_d;
      prime_count_q <= prime_count_d;
      range_error_q <= range_error_d;
    end
  end

  assign prime_valid = prime_valid_q;
  assign prime_value = prime_value_q;
  assign prime_count = prime_count_q;
  assign range_error = range_error_q;
  assign busy        = (state_q == SCAN) || (state_q == EMIT);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_varredor_primos.sv
// Directed bench for varredor_primos: range sweeps, backpressure, bounds, reset.
module tb_varredor_primos;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] lo;
  logic [15:0] hi;
  logic        out_ready;
  logic        prime_valid;
  logic [15:0] prime_value;
  logic [15:0] prime_count;
  logic        busy;
  logic        done;
  logic        range_error;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] got[$];
  int          exp_q[$];
  int          cyc;

  varredor_primos dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .lo          (lo),
    .hi          (hi),
    .out_ready   (out_ready),
    .prime_valid (prime_valid),
    .prime_value (prime_value),
    .prime_count (prime_count),
    .busy        (busy),
    .done        (done),
    .range_error (range_error)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"}, prime_valid, 0);
    check({tag, "_value"}, prime_value, 0);
    check({tag, "_count"}, prime_count, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_rerr"},  range_error, 0);
  endtask

  task automatic pulse_start(input logic [15:0] l, input logic [15:0] h);
    lo = l; hi = h; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs until done; records handshaken primes, optionally stalls on the
  // first prime and optionally pulses an (ignored) start mid-scan.
  task automatic run_scan(input string tag, input int budget, input int stall_len,
                          input logic [15:0] stall_val, input int inject_at,
                          output int cycles);
    int  stalls_left;
    bit  first_seen;
    cycles      = 0;
    stalls_left = 0;
    first_seen  = 0;
    got.delete();
    while (!done && cycles < budget) begin
      start = (cycles == inject_at);
      if (cycles == inject_at) begin lo = 16'd500; hi = 16'd600; end
      if (prime_valid && !first_seen && stall_len > 0) begin
        first_seen  = 1;
        stalls_left = stall_len;
      end
      if (stalls_left > 0) begin
        out_ready = 1'b0;
        check({tag, "_stall_valid"}, prime_valid, 1);
        check({tag, "_stall_value"}, prime_value, stall_val);
        stalls_left--;
      end else begin
        out_ready = 1'b1;
      end
      if (prime_valid && out_ready) got.push_back(prime_value);
      tick();
      cycles++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    check({tag, "_done_reached"}, done, 1);
  endtask

  task automatic compare_primes(input string tag);
    check({tag, "_nprimes"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) check($sformatf("%s_prime%0d", tag, i), got[i], exp_q[i]);
    end
  endtask

  initial begin
    clock = 1'b0; reset = 1'b1; start = 1'b0;
    lo = '0; hi = '0; out_ready = 1'b1;
    tick(); tick();
    check_idle_zero("rst");
    reset = 1'b0;
    tick();
    check_idle_zero("idle_hold");

    // 0..20 with no backpressure
    pulse_start(16'd0, 16'd20);
    check("c1_busy_start", busy, 1);
    run_scan("c1", 200, 0, 16'd0, -1, cyc);
    exp_q = '{2, 3, 5, 7, 11, 13, 17, 19};
    compare_primes("c1");
    check("c1_cycles", cyc, 29);
    check("c1_count", prime_count, 8);
    check("c1_busy_done", busy, 0);
    check("c1_rerr", range_error, 0);

    // Same range, stray start mid-scan must be ignored
    pulse_start(16'd0, 16'd20);
    run_scan("c6", 200, 0, 16'd0, 5, cyc);
    compare_primes("c6");
    check("c6_cycles", cyc, 29);
    check("c6_count", prime_count, 8);

    // Backpressure on 11 for five cycles
    pulse_start(16'd10, 16'd13);
    run_scan("c2", 100, 5, 16'd11, -1, cyc);
    exp_q = '{11, 13};
    compare_primes("c2");
    check("c2_cycles", cyc, 11);
    check("c2_count", prime_count, 2);

    // Top of the range: only 65521, no wrap to 0
    pulse_start(16'd65521, 16'd65535);
    run_scan("c3", 100, 0, 16'd0, -1, cyc);
    exp_q = '{65521};
    compare_primes("c3");
    check("c3_cycles", cyc, 16);
    for (int i = 0; i < 20; i++) tick();
    check("c3_done_held", done, 1);
    check("c3_valid_quiet", prime_valid, 0);
    check("c3_count_held", prime_count, 1);
    check("c3_busy", busy, 0);

    // Inverted bounds
    pulse_start(16'd100, 16'd50);
    check("c4_done", done, 1);
    check("c4_rerr", range_error, 1);
    check("c4_count", prime_count, 0);
    check("c4_valid", prime_valid, 0);
    check("c4_busy", busy, 0);

    // Reset in the middle of a long scan
    pulse_start(16'd0, 16'd1000);
    check("c5_rerr_cleared", range_error, 0);
    check("c5_busy", busy, 1);
    for (int i = 0; i < 49; i++) tick();
    check("c5_busy_mid", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_zero("c5_rst");
    pulse_start(16'd0, 16'd1);
    run_scan("c5b", 20, 0, 16'd0, -1, cyc);
    exp_q = {};
    compare_primes("c5b");
    check("c5b_cycles", cyc, 2);
    check("c5b_count", prime_count, 0);
    check("c5b_valid", prime_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
